// File: rtl/cpu_phi2_ctrl_if.sv
// PHI2 controller bus: clock-divider input, run/step controls and PHI2 outputs.
// The master modport is the controller side; the slave modport is the clock/CPU side.
interface cpu_phi2_ctrl_if;
    logic clk_div;
    logic run_req;
    logic step_btn_n;
    logic phi2;
    logic phi2_rise;
    logic phi2_fall;
    logic halted;

    modport master (
        input  clk_div, run_req, step_btn_n,
        output phi2, phi2_rise, phi2_fall, halted
    );

    modport slave (
        output clk_div, run_req, step_btn_n,
        input  phi2, phi2_rise, phi2_fall, halted
    );
endinterface

// File: rtl/cpu_phi2_ctrl.sv
// 65C02 PHI2 generator with run / halt / debounced single-step control in the clk_in domain.
// Optional macro CPU_CYCLE_COUNT_EN adds o_cycle_count (PHI2 rising edges since reset).
module cpu_phi2_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES  = 270000,
    parameter int unsigned STEP_HALF_CYCLES = 14
) (
    input  logic            i_clk_in,
    input  logic            i_rst_n,
`ifdef CPU_CYCLE_COUNT_EN
    output logic [31:0]     o_cycle_count,
`endif
    cpu_phi2_ctrl_if.master io_bus
);

    localparam int unsigned PhW = $clog2(STEP_HALF_CYCLES + 1);
    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PhW-1:0] PhLast = PhW'(STEP_HALF_CYCLES - 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StHalt, StRun, StStepHi, StStepLo} state_e;

    logic           r_div_s1, r_div_s2, r_div_s3;
    logic           w_div_rise, w_div_fall;
    logic           r_btn_s1, r_btn_s2, r_btn_db, r_step_evt;
    logic [DbW-1:0] r_db_cnt;
    state_e         r_state, w_state_d;
    logic [PhW-1:0] r_ph_cnt, w_ph_cnt_d;
    logic           r_phi2, w_phi2_d;
    logic           r_phi2_rise, r_phi2_fall, r_halted;

    always_ff @(posedge i_clk_in) begin
        if (!i_rst_n) begin
            r_div_s1 <= 1'b0;
            r_div_s2 <= 1'b0;
            r_div_s3 <= 1'b0;
        end else begin
            r_div_s1 <= io_bus.clk_div;
            r_div_s2 <= r_div_s1;
            r_div_s3 <= r_div_s2;
        end
    end

    assign w_div_rise = r_div_s2 & ~r_div_s3;
    assign w_div_fall = ~r_div_s2 & r_div_s3;

    // Any change of the synced button either matches the accepted level (count cleared) or
    // starts a fresh run away from it, so comparing against r_btn_db reloads on every change.
    always_ff @(posedge i_clk_in) begin
        if (!i_rst_n) begin
            r_btn_s1   <= 1'b1;
            r_btn_s2   <= 1'b1;
            r_btn_db   <= 1'b1;
            r_db_cnt   <= '0;
            r_step_evt <= 1'b0;
        end else begin
            r_btn_s1   <= io_bus.step_btn_n;
            r_btn_s2   <= r_btn_s1;
            r_step_evt <= 1'b0;
            if (r_btn_s2 == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DbLast) begin
                r_btn_db   <= r_btn_s2;
                r_db_cnt   <= '0;
                r_step_evt <= ~r_btn_s2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_phi2_d   = r_phi2;
        w_ph_cnt_d = r_ph_cnt;
        case (r_state)
            StHalt: begin
                w_phi2_d = 1'b0;
                if (io_bus.run_req && w_div_rise) begin
                    w_state_d = StRun;
                    w_phi2_d  = 1'b1;
                end else if (r_step_evt) begin
                    w_state_d  = StStepHi;
                    w_phi2_d   = 1'b1;
                    w_ph_cnt_d = '0;
                end
            end
            StRun: begin
                w_phi2_d = r_div_s2;
                if (w_div_fall && !io_bus.run_req) begin
                    w_state_d = StHalt;
                    w_phi2_d  = 1'b0;
                end
            end
            StStepHi: begin
                w_phi2_d = 1'b1;
                if (r_ph_cnt == PhLast) begin
                    w_state_d  = StStepLo;
                    w_phi2_d   = 1'b0;
                    w_ph_cnt_d = '0;
                end else begin
                    w_ph_cnt_d = r_ph_cnt + 1'b1;
                end
            end
            StStepLo: begin
                w_phi2_d = 1'b0;
                if (r_ph_cnt == PhLast) begin
                    w_state_d  = StHalt;
                    w_ph_cnt_d = '0;
                end else begin
                    w_ph_cnt_d = r_ph_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d = StHalt;
                w_phi2_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk_in) begin
        if (!i_rst_n) begin
            r_state     <= StHalt;
            r_phi2      <= 1'b0;
            r_ph_cnt    <= '0;
            r_phi2_rise <= 1'b0;
            r_phi2_fall <= 1'b0;
            r_halted    <= 1'b1;
        end else begin
            r_state     <= w_state_d;
            r_phi2      <= w_phi2_d;
            r_ph_cnt    <= w_ph_cnt_d;
            r_phi2_rise <= w_phi2_d & ~r_phi2;
            r_phi2_fall <= ~w_phi2_d & r_phi2;
            r_halted    <= (w_state_d == StHalt);
        end
    end

`ifdef CPU_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge i_clk_in) begin
        if (!i_rst_n) begin
            r_cycle_count <= 32'd0;
        end else if (w_phi2_d && !r_phi2) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign o_cycle_count = r_cycle_count;
`endif

    assign io_bus.phi2      = r_phi2;
    assign io_bus.phi2_rise = r_phi2_rise;
    assign io_bus.phi2_fall = r_phi2_fall;
    assign io_bus.halted    = r_halted;

endmodule

// File: tb/tb_cpu_phi2_ctrl.sv
// Bench for cpu_phi2_ctrl: edge times are logged and compared against clk_div timing rules.
// Build with CPU_CYCLE_COUNT_EN defined to also exercise o_cycle_count.
module tb_cpu_phi2_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rst_q = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   div_cnt = 0;
    logic div_en  = 1'b0;
    logic prev_phi2   = 1'b0;
    logic prev_halted = 1'b1;
    int   divr_q[$];
    int   rise_q[$];
    int   fall_q[$];
    int   halt_q[$];

    cpu_phi2_ctrl_if bus ();

`ifdef CPU_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    cpu_phi2_ctrl #(
        .DEBOUNCE_CYCLES (8),
        .STEP_HALF_CYCLES(14)
    ) dut (
        .i_clk_in     (clk),
        .i_rst_n      (rst_n),
`ifdef CPU_CYCLE_COUNT_EN
        .o_cycle_count(cycle_count),
`endif
        .io_bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_out(input bit sel_halted, input logic v, input int limit,
                            input string tag);
        int n;
        n = 0;
        while (((sel_halted ? bus.halted : bus.phi2) !== v) && n < limit) begin
            tick(1);
            n++;
        end
        chk(tag, n < limit, 1);
    endtask

    // Bouncy press: short (<8 cycle) segments, a solid low hold, then bouncy release.
    task automatic press(input int low_cycles);
        int nb;
        nb = $urandom_range(2, 4);
        for (int i = 0; i < nb; i++) begin
            bus.step_btn_n = 1'b0;
            tick($urandom_range(1, 5));
            bus.step_btn_n = 1'b1;
            tick($urandom_range(1, 5));
        end
        bus.step_btn_n = 1'b0;
        tick(low_cycles);
        for (int i = 0; i < nb; i++) begin
            bus.step_btn_n = 1'b1;
            tick($urandom_range(1, 5));
            bus.step_btn_n = 1'b0;
            tick($urandom_range(1, 5));
        end
        bus.step_btn_n = 1'b1;
    endtask

    // clk_div: toggles every 27 clk_in cycles, changed just after a posedge.
    initial begin
        bus.clk_div = 1'b0;
        wait (div_en);
        forever begin
            @(posedge clk);
            #1;
            div_cnt++;
            if (div_cnt >= 27) begin
                div_cnt     = 0;
                bus.clk_div = ~bus.clk_div;
                if (bus.clk_div) divr_q.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_q) begin
            chk("reset_outputs", {bus.phi2, bus.phi2_rise, bus.phi2_fall, bus.halted}, 4'b0001);
            prev_phi2   = 1'b0;
            prev_halted = 1'b1;
        end else begin
            chk("strobes", {bus.phi2_rise, bus.phi2_fall},
                {bus.phi2 & ~prev_phi2, ~bus.phi2 & prev_phi2});
            if (bus.phi2 && !prev_phi2) rise_q.push_back(cyc);
            if (!bus.phi2 && prev_phi2) fall_q.push_back(cyc);
            if (bus.halted && !prev_halted) halt_q.push_back(cyc);
            prev_phi2   = bus.phi2;
            prev_halted = bus.halted;
        end
    end

    initial begin
        int r0, f0, h0, t0, t1, n_exp, n_got, rr, ff, exp_r;
        bit hit;

        bus.run_req    = 1'b1;
        bus.step_btn_n = 1'b1;
        rst_n          = 1'b0;
        tick(2);
        chk("reset_halted", bus.halted, 1'b1);
        chk("reset_phi2", bus.phi2, 1'b0);
        rst_n   = 1'b1;
        div_cnt = $urandom_range(0, 26);
        div_en  = 1'b1;

        // Free run: first rise 3 cycles after first clk_div rise, 27/27 thereafter.
        wait_out(1'b0, 1'b1, 200, "run_first_rise_timeout");
        chk("run_first_rise_lag", rise_q.size() > 0 && divr_q.size() > 0 ? rise_q[0] - divr_q[0] : -1, 3);
        tick(54 * 3 + 5);
        chk("run_rise_count", rise_q.size(), 4);
        if (rise_q.size() >= 4 && fall_q.size() >= 3) begin
            for (int i = 1; i < 4; i++) begin
                chk("run_period", rise_q[i] - rise_q[i-1], 54);
                chk("run_high", fall_q[i-1] - rise_q[i-1], 27);
            end
        end
        chk("run_halted", bus.halted, 1'b0);
`ifdef CPU_CYCLE_COUNT_EN
        chk("cycle_count_run", cycle_count, rise_q.size());
`endif

        // Drop run_req during a high phase: phase still lasts 27, then halt and stay quiet.
        wait_out(1'b0, 1'b0, 100, "drop_wait_low");
        wait_out(1'b0, 1'b1, 100, "drop_wait_high");
        t0 = cyc;
        tick($urandom_range(1, 20));
        bus.run_req = 1'b0;
        wait_out(1'b0, 1'b0, 100, "drop_fall_timeout");
        chk("drop_high_len", cyc - t0, 27);
        chk("drop_halted", bus.halted, 1'b1);
        r0 = rise_q.size();
        f0 = fall_q.size();
        tick(500);
        chk("halt_no_rise", rise_q.size(), r0);
        chk("halt_no_fall", fall_q.size(), f0);
        chk("halt_still", bus.halted, 1'b1);

        // Bouncy single step from HALT.
        r0 = rise_q.size();
        f0 = fall_q.size();
        h0 = halt_q.size();
        press(20);
        tick(100);
        chk("step_rises", rise_q.size() - r0, 1);
        chk("step_falls", fall_q.size() - f0, 1);
        chk("step_halts", halt_q.size() - h0, 1);
        if (rise_q.size() == r0 + 1 && fall_q.size() == f0 + 1 && halt_q.size() == h0 + 1) begin
            chk("step_high_len", fall_q[f0] - rise_q[r0], 14);
            chk("step_low_len", halt_q[h0] - fall_q[f0], 14);
        end
        chk("step_halted", bus.halted, 1'b1);

        // Long hold gives a single step.
        r0 = rise_q.size();
        bus.step_btn_n = 1'b0;
        tick(1000);
        bus.step_btn_n = 1'b1;
        tick(40);
        chk("hold_one_step", rise_q.size() - r0, 1);

        // Step press while running leaves the clk_div-derived waveform untouched.
        bus.run_req = 1'b1;
        wait_out(1'b0, 1'b1, 200, "run2_timeout");
        t0 = cyc;
        r0 = rise_q.size();
        press(30);
        tick(200);
        t1 = cyc;
        n_exp = 0;
        n_got = 0;
        foreach (divr_q[j]) if (divr_q[j] + 3 > t0 && divr_q[j] + 3 <= t1) n_exp++;
        foreach (rise_q[i]) if (rise_q[i] > t0 && rise_q[i] <= t1) n_got++;
        chk("run_step_rise_count", n_got, n_exp);
        for (int i = r0; i < rise_q.size(); i++) begin
            hit = 1'b0;
            foreach (divr_q[j]) if (divr_q[j] + 3 == rise_q[i]) hit = 1'b1;
            chk("run_step_aligned", hit, 1'b1);
        end

        // run_req during STEP_HI: full 14/14 step, then RUN on the next clk_div rise.
        bus.run_req = 1'b0;
        wait_out(1'b1, 1'b1, 200, "halt2_timeout");
        tick(30);
        bus.step_btn_n = 1'b0;
        wait_out(1'b0, 1'b1, 50, "step5_timeout");
        rr = cyc;
        tick($urandom_range(1, 10));
        bus.run_req    = 1'b1;
        bus.step_btn_n = 1'b1;
        wait_out(1'b0, 1'b0, 50, "step5_fall_timeout");
        ff = cyc;
        chk("step5_high_len", ff - rr, 14);
        wait_out(1'b0, 1'b1, 200, "run5_timeout");
        exp_r = -1;
        foreach (divr_q[j]) if (exp_r < 0 && divr_q[j] + 3 >= ff + 15) exp_r = divr_q[j] + 3;
        chk("run5_start", cyc, exp_r);
        rr = cyc;
        wait_out(1'b0, 1'b0, 100, "run5_fall_timeout");
        chk("run5_high_len", cyc - rr, 27);

        // Reset in the middle of STEP_HI.
        bus.run_req = 1'b0;
        wait_out(1'b1, 1'b1, 200, "halt3_timeout");
        tick(30);
        bus.step_btn_n = 1'b0;
        wait_out(1'b0, 1'b1, 50, "step6_timeout");
        tick($urandom_range(1, 10));
        rst_n          = 1'b0;
        bus.step_btn_n = 1'b1;
        tick(1);
        chk("rst_mid_phi2", bus.phi2, 1'b0);
        chk("rst_mid_halted", bus.halted, 1'b1);
        rst_n = 1'b1;
        r0 = rise_q.size();
        tick(100);
        chk("rst_mid_quiet", rise_q.size(), r0);
`ifdef CPU_CYCLE_COUNT_EN
        chk("cycle_count_reset", cycle_count, 32'd0);
        force dut.r_cycle_count = 32'hFFFF_FFFF;
        tick(1);
        release dut.r_cycle_count;
        bus.run_req = 1'b1;
        wait_out(1'b0, 1'b1, 200, "wrap_timeout");
        chk("cycle_count_wrap", cycle_count, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
